// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_share_arbiter
// Brief    : Round-robin sharing of one pipelined adder among NREQ requesters,
//            with a tag shadow pipe that routes each sum back to its issuer.
// Revision : 1.0
// ============================================================================
module adder_share_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  add_v_in,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic                  add_v_out,
    input  logic [WIDTH-1:0]      add_sum,
    output logic [NREQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]      resp_sum,
    output logic                  idle,
    output logic                  err
);

    localparam int c_id_w  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_inf_w = $clog2(ADD_LAT + 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_grant_en;

    logic [c_id_w-1:0]  r_rr_ptr;
    logic [c_inf_w-1:0] r_inflight;
    logic [c_id_w-1:0]  r_issue_id;

    logic               r_add_v_in;
    logic [WIDTH-1:0]   r_add_a;
    logic [WIDTH-1:0]   r_add_b;
    logic               r_add_cin;

    logic [NREQ-1:0]    r_resp_valid;
    logic [WIDTH-1:0]   r_resp_sum;
    logic               r_err;

    logic               r_tag_v  [ADD_LAT];
    logic [c_id_w-1:0]  r_tag_id [ADD_LAT];
    logic               w_exit_v;
    logic [c_id_w-1:0]  w_exit_id;

    logic [WIDTH-1:0]   w_a_arr [NREQ];
    logic [WIDTH-1:0]   w_b_arr [NREQ];

    logic               w_gnt_found;
    logic [c_id_w-1:0]  w_gnt_id;
    logic [c_id_w-1:0]  w_scan;

    // Unpack the flat operand buses so the winner can be selected by index.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign w_b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !flush) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_grant_en = 1'b1;
                end
            end
            S_DRAIN: begin
                // add_v_in covers the op issued just before flush that has not
                // yet entered the tag pipe.
                if ((r_inflight == '0) && !r_add_v_in) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Round-robin search starting just after the last winner
    // ------------------------------------------------------------------------
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        w_scan      = r_rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (w_scan == c_id_w'(NREQ - 1)) begin
                w_scan = '0;
            end else begin
                w_scan = w_scan + 1'b1;
            end
            if (w_grant_en && !w_gnt_found && req_valid[w_scan]) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = w_scan;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_gnt_found) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Issue register towards the adder
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= c_id_w'(NREQ - 1);
            r_issue_id <= '0;
            r_add_v_in <= 1'b0;
            r_add_a    <= '0;
            r_add_b    <= '0;
            r_add_cin  <= 1'b0;
        end else begin
            r_add_v_in <= w_gnt_found;
            if (w_gnt_found) begin
                r_rr_ptr   <= w_gnt_id;
                r_issue_id <= w_gnt_id;
                r_add_a    <= w_a_arr[w_gnt_id];
                r_add_b    <= w_b_arr[w_gnt_id];
                r_add_cin  <= req_cin[w_gnt_id];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Tag shadow pipe: stage 0 captures the op the adder samples this edge,
    // so the last stage lines up with the adder's v_out.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < ADD_LAT; s++) begin
                r_tag_v[s]  <= 1'b0;
                r_tag_id[s] <= '0;
            end
        end else begin
            r_tag_v[0]  <= r_add_v_in;
            r_tag_id[0] <= r_issue_id;
            for (int s = 1; s < ADD_LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    assign w_exit_v  = r_tag_v[ADD_LAT-1];
    assign w_exit_id = r_tag_id[ADD_LAT-1];

    // ------------------------------------------------------------------------
    // Response routing, error flag and in-flight counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= '0;
            r_resp_sum   <= '0;
            r_err        <= 1'b0;
            r_inflight   <= '0;
        end else begin
            r_resp_valid <= '0;
            // A v_out without a live tag is a leftover from before reset.
            if (w_exit_v && add_v_out) begin
                r_resp_valid[w_exit_id] <= 1'b1;
                r_resp_sum              <= add_sum;
            end
            if (w_exit_v && !add_v_out) begin
                r_err <= 1'b1;
            end
            case ({r_add_v_in, w_exit_v})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign add_v_in   = r_add_v_in;
    assign add_a      = r_add_a;
    assign add_b      = r_add_b;
    assign add_cin    = r_add_cin;
    assign resp_valid = r_resp_valid;
    assign resp_sum   = r_resp_sum;
    assign err        = r_err;
    assign idle       = (r_state == S_IDLE) && (r_inflight == '0);

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_share_arbiter
// Brief    : Directed bench with stub adder and in-order response scoreboard.
// Revision : 1.0
// ============================================================================
module tb_adder_share_arbiter;

    localparam int WIDTH   = 16;
    localparam int NREQ    = 4;
    localparam int ADD_LAT = 6;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  flush;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic                  add_v_in;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_cin;
    logic                  add_v_out;
    logic [WIDTH-1:0]      add_sum;
    logic [NREQ-1:0]       resp_valid;
    logic [WIDTH-1:0]      resp_sum;
    logic                  idle;
    logic                  err;

    adder_share_arbiter #(
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .ADD_LAT (ADD_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .add_v_in   (add_v_in),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_v_out  (add_v_out),
        .add_sum    (add_sum),
        .resp_valid (resp_valid),
        .resp_sum   (resp_sum),
        .idle       (idle),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub adder: never reset, so ops in flight across a DUT reset still emerge.
    logic                 kill;
    logic [ADD_LAT-1:0]   stub_v = '0;
    logic [WIDTH-1:0]     stub_s [ADD_LAT];
    always @(posedge clk) begin
        stub_v    <= {stub_v[ADD_LAT-2:0], add_v_in && !kill};
        stub_s[0] <= add_a + add_b + {{(WIDTH-1){1'b0}}, add_cin};
        for (int s = 1; s < ADD_LAT; s++) stub_s[s] <= stub_s[s-1];
    end
    assign add_v_out = stub_v[ADD_LAT-1];
    assign add_sum   = stub_s[ADD_LAT-1];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          id;
        logic [15:0] sum;
        int          cyc;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (resp_valid != '0) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: resp_valid=%b sum=0x%0h, none expected (cycle %0d)",
                         resp_valid, resp_sum, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("resp_valid", 32'(resp_valid), 32'(1 << mon_e.id));
                chk("resp_sum", 32'(resp_sum), 32'(mon_e.sum));
                chk("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    logic [15:0] exp_sum [NREQ];
    int          rnd [NREQ];
    logic [15:0] t2a [3][4];
    logic [15:0] t2b [3][4];
    logic        t2c [3][4];
    logic [15:0] t2s [3][4];
    int          hs_last;
    int          h_b;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [15:0] s);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_cin[i]              = c;
        exp_sum[i]              = s;
    endtask

    // Present valids, check the grant at mid-cycle, and log the expected result.
    task automatic cycle_chk(input logic [NREQ-1:0] v, input int g, input bit push,
                             input string name);
        req_valid = v;
        @(negedge clk);
        chk(name, 32'(req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
        if (g >= 0) begin
            hs_last = cyc;
            if (push) sbq.push_back('{g, exp_sum[g], cyc + ADD_LAT + 2});
        end
    endtask

    task automatic idle_cycles(input int n);
        req_valid = '0;
        repeat (n) tick();
    endtask

    task automatic wait_until(input int t);
        for (int n = 0; n < 500 && cyc < t; n++) tick();
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; kill = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
        for (int i = 0; i < NREQ; i++) exp_sum[i] = '0;
        t2a = '{'{16'h1000, 16'h2000, 16'h3000, 16'h4000},
                '{16'h1111, 16'h2222, 16'h3333, 16'h8000},
                '{16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        t2b = '{'{16'h0010, 16'h0020, 16'h0030, 16'h0040},
                '{16'h0101, 16'h0202, 16'h0303, 16'h8000},
                '{16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        t2c = '{'{1'b0, 1'b0, 1'b0, 1'b0},
                '{1'b1, 1'b1, 1'b1, 1'b1},
                '{1'b0, 1'b0, 1'b0, 1'b0}};
        t2s = '{'{16'h1010, 16'h2020, 16'h3030, 16'h4040},
                '{16'h1213, 16'h2425, 16'h3637, 16'h0001},
                '{16'h0000, 16'h0000, 16'h0000, 16'h0000}};

        repeat (3) tick();
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_add_v_in", 32'(add_v_in), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_sum", 32'(resp_sum), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // flush beats start in IDLE: no grant afterwards
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        cycle_chk(4'b0001, -1, 1'b1, "flush_beats_start");
        tick();
        do_start();

        // T1: single op, exact latency
        set_op(0, 16'h1234, 16'h0001, 1'b1, 16'h1236);
        cycle_chk(4'b0001, 0, 1'b1, "t1_grant");
        tick();
        @(negedge clk);
        chk("t1_add_v_in", 32'(add_v_in), 32'd1);
        chk("t1_add_a", 32'(add_a), 32'h1234);
        chk("t1_not_idle", 32'(idle), 32'd0);
        cycle_chk(4'b0000, -1, 1'b1, "t1_drop");
        tick();
        @(negedge clk);
        chk("t1_add_a_hold", 32'(add_a), 32'h1234);
        idle_cycles(ADD_LAT + 4);

        // T2: four requesters contending, round-robin from 0
        do_reset();
        do_start();
        for (int i = 0; i < NREQ; i++) begin
            rnd[i] = 0;
            set_op(i, t2a[0][i], t2b[0][i], t2c[0][i], t2s[0][i]);
        end
        for (int k = 0; k < 8; k++) begin
            cycle_chk(4'b1111, k % 4, 1'b1, "t2_grant");
            tick();
            rnd[k % 4]++;
            set_op(k % 4, t2a[rnd[k % 4]][k % 4], t2b[rnd[k % 4]][k % 4],
                   t2c[rnd[k % 4]][k % 4], t2s[rnd[k % 4]][k % 4]);
        end
        idle_cycles(ADD_LAT + 4);

        // T3: carry-out dropped
        set_op(1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000);
        cycle_chk(4'b0010, 1, 1'b1, "t3_grant_a");
        tick();
        set_op(2, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF);
        cycle_chk(4'b0100, 2, 1'b1, "t3_grant_b");
        tick();
        idle_cycles(ADD_LAT + 4);

        // T4: flush with three ops in flight
        set_op(3, 16'h0F0F, 16'h00F0, 1'b0, 16'h0FFF);
        set_op(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000);
        set_op(1, 16'hAAAA, 16'h5555, 1'b1, 16'h0000);
        cycle_chk(4'b1111, 3, 1'b1, "t4_grant");
        tick();
        cycle_chk(4'b1111, 0, 1'b1, "t4_grant");
        tick();
        cycle_chk(4'b1111, 1, 1'b1, "t4_grant");
        tick();
        flush = 1'b1;
        cycle_chk(4'b1111, -1, 1'b1, "t4_flush_cycle");
        tick();
        flush = 1'b0;
        for (int n = 0; n < 40 && cyc < hs_last + ADD_LAT + 2; n++) begin
            cycle_chk(4'b1111, -1, 1'b1, "t4_drain_ready");
            tick();
        end
        @(negedge clk);
        chk("t4_idle_at_last_resp", 32'(idle), 32'd0);
        tick();
        @(negedge clk);
        chk("t4_idle_after", 32'(idle), 32'd1);
        chk("t4_idle_ready", 32'(req_ready), 32'd0);
        idle_cycles(2);

        // T5: reset with four ops in flight, stale v_outs must be dropped
        do_start();
        for (int i = 0; i < NREQ; i++) set_op(i, 16'(16'h0100 * (i + 1)), 16'h0011, 1'b0, 16'h0000);
        cycle_chk(4'b1111, 2, 1'b1, "t5_grant");
        tick();
        cycle_chk(4'b1111, 3, 1'b1, "t5_grant");
        tick();
        cycle_chk(4'b1111, 0, 1'b1, "t5_grant");
        tick();
        cycle_chk(4'b1111, 1, 1'b1, "t5_grant");
        tick();
        sbq.delete();
        do_reset();
        idle_cycles(ADD_LAT + 4);
        @(negedge clk);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_idle", 32'(idle), 32'd1);
        tick();
        do_start();
        set_op(2, 16'h0102, 16'h0304, 1'b1, 16'h0407);
        cycle_chk(4'b0100, 2, 1'b1, "t5_resume");
        tick();
        idle_cycles(ADD_LAT + 4);

        // T6: adder swallows the middle op
        set_op(3, 16'h1000, 16'h0001, 1'b0, 16'h1001);
        set_op(0, 16'h2000, 16'h0002, 1'b1, 16'h2003);
        set_op(1, 16'h0003, 16'h0004, 1'b0, 16'h0007);
        cycle_chk(4'b1111, 3, 1'b1, "t6_grant");
        tick();
        cycle_chk(4'b1111, 0, 1'b0, "t6_grant");
        h_b = hs_last;
        tick();
        kill = 1'b1;
        cycle_chk(4'b1111, 1, 1'b1, "t6_grant");
        tick();
        kill = 1'b0;
        req_valid = '0;
        wait_until(h_b + ADD_LAT + 1);
        @(negedge clk);
        chk("t6_err_before", 32'(err), 32'd0);
        tick();
        @(negedge clk);
        chk("t6_err_set", 32'(err), 32'd1);
        idle_cycles(10);
        @(negedge clk);
        chk("t6_err_sticky", 32'(err), 32'd1);
        tick();
        do_reset();
        @(negedge clk);
        chk("t6_err_cleared", 32'(err), 32'd0);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
